// File: rtl/power_spectrum.sv
// power_spectrum: half-spectrum power stage behind the FFT output.
// Computes |X|^2 = re^2 + im^2 for each FFT bin, shifts it right by SHIFT and
// saturates it to O_BW bits. Only bins 0..FFT_N/2 are passed on. Each result
// carries its bin index, a last-bin flag and a frame index.
// There is a fixed three-register pipeline: S1 (operands and tags), S2 (squares)
// and S3 (sum, shift and saturate into the outputs).
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   di_en, di_first  sample valid; di_first forces the sample to bin 0 (resync)
//   di_re, di_im     signed I_BW-bit complex sample
//   do_en            one-cycle result valid
//   do_pow           unsigned O_BW-bit shifted, saturated power
//   do_bin           bin index of do_pow
//   do_last          high with do_en on bin FFT_N/2
//   frame_idx        frame number of the result, wraps 65535 -> 0
//   ovf              sticky saturation flag, cleared only by rst
module power_spectrum #(
  parameter int unsigned I_BW  = 14,
  parameter int unsigned O_BW  = 16,
  parameter int unsigned SHIFT = 13,
  parameter int unsigned FFT_N = 512
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             di_en,
  input  logic                             di_first,
  input  logic [I_BW-1:0]                  di_re,
  input  logic [I_BW-1:0]                  di_im,
  output logic                             do_en,
  output logic [O_BW-1:0]                  do_pow,
  output logic [$clog2(FFT_N/2+1)-1:0]     do_bin,
  output logic                             do_last,
  output logic [15:0]                      frame_idx,
  output logic                             ovf
);

  localparam int unsigned BIN_W = $clog2(FFT_N);
  localparam int unsigned OB_W  = $clog2(FFT_N/2+1);
  localparam int unsigned SQ_W  = 2*I_BW;
  localparam int unsigned SUM_W = SQ_W + 1;
  localparam int unsigned HALF  = FFT_N/2;

  // Input-side counters
  logic [BIN_W-1:0] bin_cnt;
  logic [15:0]      frame_cnt;
  logic             started;

  // Pipeline registers
  logic                   s1_vld;
  logic signed [I_BW-1:0] s1_re;
  logic signed [I_BW-1:0] s1_im;
  logic [OB_W-1:0]        s1_bin;
  logic [15:0]            s1_tag;

  logic                   s2_vld;
  logic [SQ_W-1:0]        s2_re2;
  logic [SQ_W-1:0]        s2_im2;
  logic [OB_W-1:0]        s2_bin;
  logic [15:0]            s2_tag;

  // Combinational helpers
  logic [BIN_W-1:0]       eff_bin_c;
  logic                   at_zero_c;
  logic [15:0]            tag_c;
  logic                   keep_c;
  logic signed [SQ_W-1:0] re_sq_c;
  logic signed [SQ_W-1:0] im_sq_c;
  logic [SUM_W-1:0]       sum_c;
  logic [SUM_W-1:0]       shifted_c;
  logic                   sat_c;
  logic [O_BW-1:0]        pow_c;

  // Effective bin and frame tag for the sample on the input this cycle
  always_comb begin
    eff_bin_c = di_first ? '0 : bin_cnt;
    at_zero_c = (eff_bin_c == '0);
    // Bin 0 opens a new frame, except for the very first frame after reset
    tag_c     = (at_zero_c && started) ? frame_cnt + 16'd1 : frame_cnt;
    keep_c    = di_en && (eff_bin_c <= BIN_W'(HALF));
  end

  // Bin counter, frame counter and started flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt   <= '0;
      frame_cnt <= '0;
      started   <= 1'b0;
    end else if (di_en) begin
      bin_cnt <= eff_bin_c + BIN_W'(1);
      if (at_zero_c) begin
        started   <= 1'b1;
        frame_cnt <= tag_c;
      end
    end
  end

  // S1: capture operands and tags for kept bins
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= keep_c;
      if (keep_c) begin
        s1_re  <= di_re;
        s1_im  <= di_im;
        s1_bin <= OB_W'(eff_bin_c);
        s1_tag <= tag_c;
      end
    end
  end

  // Operands are sign-extended first so the product is computed at full width
  always_comb begin
    re_sq_c = SQ_W'(s1_re) * SQ_W'(s1_re);
    im_sq_c = SQ_W'(s1_im) * SQ_W'(s1_im);
  end

  // S2: squares
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_re2 <= $unsigned(re_sq_c);
        s2_im2 <= $unsigned(im_sq_c);
        s2_bin <= s1_bin;
        s2_tag <= s1_tag;
      end
    end
  end

  // Exact sum, then floor shift, then saturate to O_BW bits
  always_comb begin
    sum_c     = SUM_W'(s2_re2) + SUM_W'(s2_im2);
    shifted_c = sum_c >> SHIFT;
    sat_c     = (shifted_c >> O_BW) != '0;
    pow_c     = sat_c ? {O_BW{1'b1}} : O_BW'(shifted_c);
  end

  // S3: outputs; payload holds while do_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      do_en     <= 1'b0;
      do_pow    <= '0;
      do_bin    <= '0;
      do_last   <= 1'b0;
      frame_idx <= '0;
      ovf       <= 1'b0;
    end else begin
      do_en   <= s2_vld;
      do_last <= s2_vld && (s2_bin == OB_W'(HALF));
      if (s2_vld) begin
        do_pow    <= pow_c;
        do_bin    <= s2_bin;
        frame_idx <= s2_tag;
        if (sat_c) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_power_spectrum.sv
// Randomized bench for power_spectrum. Two instances share the same stimulus:
// one uses the default SHIFT=13 and the other uses SHIFT=0, so that saturation
// occurs often. The reference model works at the transaction level. It works out
// the bin, frame and power of each sample with plain integer arithmetic. It then
// schedules the result three cycles after the sample is presented.
module tb_power_spectrum;

  localparam int N    = 512;
  localparam int HALF = N/2;

  logic        clk;
  logic        rst;
  logic        di_en;
  logic        di_first;
  logic [13:0] di_re;
  logic [13:0] di_im;

  logic        en0, last0, ovf0, en1, last1, ovf1;
  logic [15:0] pow0, pow1, fr0, fr1;
  logic [8:0]  bin0, bin1;

  power_spectrum #(.I_BW(14), .O_BW(16), .SHIFT(13), .FFT_N(N)) dut0 (
    .clk(clk), .rst(rst), .di_en(di_en), .di_first(di_first),
    .di_re(di_re), .di_im(di_im), .do_en(en0), .do_pow(pow0), .do_bin(bin0),
    .do_last(last0), .frame_idx(fr0), .ovf(ovf0));

  power_spectrum #(.I_BW(14), .O_BW(16), .SHIFT(0), .FFT_N(N)) dut1 (
    .clk(clk), .rst(rst), .di_en(di_en), .di_first(di_first),
    .di_re(di_re), .di_im(di_im), .do_en(en1), .do_pow(pow1), .do_bin(bin1),
    .do_last(last1), .frame_idx(fr1), .ovf(ovf1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int due;
    int sum;
    int bin;
    int tag;
  } res_t;

  res_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   m_bin = 0;
  int   m_frame = 0;
  bit   m_started = 0;
  bit   x_en = 0;
  int   h_bin = 0;
  int   h_frame = 0;
  int   h_pow[2] = '{0, 0};
  bit   m_ovf[2] = '{0, 0};
  int   shifts[2] = '{13, 0};
  int   pulses;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int pow_of(input int sum, input int sh);
    int p;
    p = sum >> sh;
    return (p > 65535) ? 65535 : p;
  endfunction

  // Present one cycle of stimulus, advance the model across the edge, compare
  task automatic step(input bit r, input bit en, input bit first, input int re, input int im);
    res_t e;
    int   eb;
    rst = r; di_en = en; di_first = first;
    di_re = 14'(re); di_im = 14'(im);
    @(posedge clk); #1;
    cyc++;
    x_en = 0;
    if (r) begin
      q.delete();
      m_bin = 0; m_frame = 0; m_started = 0;
      h_bin = 0; h_frame = 0;
      for (int d = 0; d < 2; d++) begin h_pow[d] = 0; m_ovf[d] = 0; end
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        x_en = 1;
        h_bin = e.bin;
        h_frame = e.tag;
        for (int d = 0; d < 2; d++) begin
          h_pow[d] = pow_of(e.sum, shifts[d]);
          if ((e.sum >> shifts[d]) > 65535) m_ovf[d] = 1;
        end
      end
      if (en) begin
        eb = first ? 0 : m_bin;
        if (eb == 0) begin
          if (m_started) m_frame = (m_frame + 1) % 65536;
          m_started = 1;
        end
        if (eb <= HALF) begin
          e.due = cyc + 2;
          e.sum = re*re + im*im;
          e.bin = eb;
          e.tag = m_frame;
          q.push_back(e);
        end
        m_bin = (eb + 1) % N;
      end
    end
    check("do_en0",   en0,   x_en);
    check("do_pow0",  pow0,  h_pow[0]);
    check("do_bin0",  bin0,  h_bin);
    check("do_last0", last0, x_en && h_bin == HALF);
    check("frame0",   fr0,   h_frame);
    check("ovf0",     ovf0,  m_ovf[0]);
    check("do_en1",   en1,   x_en);
    check("do_pow1",  pow1,  h_pow[1]);
    check("do_bin1",  bin1,  h_bin);
    check("do_last1", last1, x_en && h_bin == HALF);
    check("frame1",   fr1,   h_frame);
    check("ovf1",     ovf1,  m_ovf[1]);
    pulses += en0;
  endtask

  function automatic int rnd14();
    return int'($urandom_range(16383, 0)) - 8192;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; di_en = 1'b0; di_first = 1'b0; di_re = '0; di_im = '0;
    pulses = 0;

    // Reset with di_en toggling
    step(1, 1, 0, rnd14(), rnd14());
    step(1, 0, 0, rnd14(), rnd14());

    // First sample after reset
    step(0, 1, 0, 8191, 8191);
    idle(4);

    // Full frame of constant samples, then the start of a second frame
    pulses = 0;
    step(0, 1, 1, -8192, 0);
    for (int i = 1; i < N; i++) step(0, 1, 0, -8192, 0);
    idle(3);
    check("frame_pulses", pulses, HALF + 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, rnd14(), rnd14());
    idle(3);

    // Gapped input
    for (int i = 0; i < 20; i++) begin
      step(0, 1, i == 0, rnd14(), rnd14());
      step(0, 0, 0, rnd14(), rnd14());
    end
    idle(3);

    // Resync mid-frame
    for (int i = 0; i < 100; i++) step(0, 1, 0, rnd14(), rnd14());
    step(0, 1, 1, rnd14(), rnd14());
    step(0, 1, 0, rnd14(), rnd14());
    idle(3);

    // Saturation on the SHIFT=0 instance, then a small value
    step(0, 1, 0, 300, 0);
    step(0, 1, 0, 3, -4);
    idle(3);

    // Reset with samples in flight
    step(0, 1, 1, rnd14(), rnd14());
    for (int i = 1; i <= 150; i++) step(0, 1, 0, rnd14(), rnd14());
    step(1, 1, 0, rnd14(), rnd14());
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 5, 6);
    idle(3);

    // Random traffic with occasional resync and reset
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(999, 0) < 3,
           $urandom_range(99, 0) < 70,
           $urandom_range(99, 0) < 2,
           rnd14(), rnd14());
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
